// File: rtl/cotm32_pkg.sv
// ---------------------------------------------------------------------------
// cotm32_pkg
// Shared types and defaults for the data-memory response block.
//   XLEN / BYTE_WIDTH      : datapath width and byte lane width
//   NUM_LANES              : byte lanes per word
//   DMEM_DEPTH_WORDS       : default data memory depth in words
//   DMEM_BASE_ADDR         : default byte address of word 0
//   dmem_state_t           : IDLE / READ / RESP handshake states
//   addr_bits()            : word-index width for a given depth
// ---------------------------------------------------------------------------
package cotm32_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned BYTE_WIDTH       = 8;
    localparam int unsigned NUM_LANES        = XLEN / BYTE_WIDTH;
    localparam int unsigned DMEM_DEPTH_WORDS = 1024;
    localparam logic [XLEN-1:0] DMEM_BASE_ADDR = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // A depth of one word still needs a one-bit index port.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram
// Single-port word RAM with synchronous read and per-byte write enables.
//   i_clk    : clock
//   i_we     : per-lane write enable (lane k = bits [8k+7:8k])
//   i_re     : read enable; o_rdata updates on the following edge
//   i_addr   : word index
//   i_wdata  : write word, already lane-aligned
//   o_rdata  : registered read word
// ---------------------------------------------------------------------------
module dmem_ram
    import cotm32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned AW          = addr_bits(DEPTH_WORDS)
) (
    input  logic                 i_clk,
    input  logic [NUM_LANES-1:0] i_we,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_addr,
    input  logic [XLEN-1:0]      i_wdata,
    output logic [XLEN-1:0]      o_rdata
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // NOTE: storage arrays carry no reset; clearing them would force flops
    // instead of RAM macros, and their contents must survive reset anyway.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_we[k]) begin
                mem_q[i_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (i_re) begin
            o_rdata <= mem_q[i_addr];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp
// Data-memory slave with valid/ready request and response channels.
// Writes and faults answer one cycle after acceptance, reads two cycles
// after acceptance. One request is outstanding at a time.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_req_valid/o_req_ready : request handshake (ready only in IDLE)
//   i_addr                  : byte address
//   i_we                    : 1 = write, 0 = read
//   i_wdata / i_wstrb       : right-aligned store data and strobe
//   o_rsp_valid/i_rsp_ready : response handshake
//   o_rdata                 : load word shifted so addressed byte is [7:0]
//   o_rsp_err               : access fault
// ---------------------------------------------------------------------------
module dmem_resp
    import cotm32_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter logic [XLEN-1:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [XLEN-1:0]       i_addr,
    input  logic                  i_we,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic [XLEN/BYTE_WIDTH-1:0] i_wstrb,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [XLEN-1:0]       o_rdata,
    output logic                  o_rsp_err
);

    localparam int unsigned AW = addr_bits(DEPTH_WORDS);

    dmem_state_t          state_q;
    logic [1:0]           off_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [XLEN-1:0]      rdata_q;

    logic [1:0]           off;
    logic [XLEN-1:0]      word_idx;
    logic [2*NUM_LANES-1:0] strb_sh;
    logic                 fault;
    logic                 accept;
    logic                 do_write;
    logic                 do_read;
    logic [NUM_LANES-1:0] ram_we;
    logic [XLEN-1:0]      ram_wdata;
    logic [XLEN-1:0]      ram_dout;

    assign off      = i_addr[1:0];
    assign word_idx = (i_addr - BASE_ADDR) >> 2;

    // Shifted into a double-width field so lanes pushed past bit 3 stay
    // visible and can be flagged as a misaligned store.
    assign strb_sh  = {{NUM_LANES{1'b0}}, i_wstrb} << off;

    assign fault    = (i_addr < BASE_ADDR)
                    | (word_idx >= DEPTH_WORDS)
                    | (i_we & (|strb_sh[2*NUM_LANES-1:NUM_LANES]));

    assign accept   = i_req_valid & (state_q == IDLE);
    // Reset gates the write so a request presented during reset cannot
    // reach the array (the FSM sits in IDLE and would otherwise accept).
    assign do_write = accept & i_we & ~fault & i_rst_n;
    assign do_read  = accept & ~i_we & ~fault;

    assign ram_we    = do_write ? strb_sh[NUM_LANES-1:0] : '0;
    assign ram_wdata = i_wdata << {off, 3'b000};

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_re    (do_read),
        .i_addr  (word_idx[AW-1:0]),
        .i_wdata (ram_wdata),
        .o_rdata (ram_dout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            off_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        if (fault || i_we) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= fault;
                            rdata_q     <= '0;
                        end else begin
                            state_q <= READ;
                            off_q   <= off;
                        end
                    end
                end
                READ: begin
                    // Zero-filled shift; upper bytes are not masked.
                    rdata_q     <= ram_dout >> {off_q, 3'b000};
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_resp dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_addr      (addr),
        .i_we        (we),
        .i_wdata     (wdata),
        .i_wstrb     (wstrb),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rdata     (rdata),
        .o_rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one request, wait for its response (bounded), return latency
    // in cycles from the acceptance edge (-1 if no response appeared).
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output int lat,
                        output logic [31:0] rd, output logic er);
        @(negedge clk);
        req_valid = 1'b1;
        addr      = a;
        we        = w;
        wdata     = d;
        wstrb     = s;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
        rd = rdata;
        er = rsp_err;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; addr = '0; we = 1'b0; wdata = '0; wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, want 0 0 00000000", rsp_valid, rsp_err, rdata);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0000, 1'b1, 32'hDEAD_BEEF, 4'b1111, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL word_write: lat=%0d err=%b rdata=%h, want 1 0 00000000", lat, er, rd);
        end
        consume();
        xfer(32'h0001_0000, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL word_read: lat=%0d err=%b rdata=%h, want 2 0 deadbeef", lat, er, rd);
        end
        consume();
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0000, 1'b1, 32'h1122_3344, 4'b1111, lat, rd, er);
        consume();
        xfer(32'h0001_0002, 1'b1, 32'h0000_00AA, 4'b0001, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL byte_write: lat=%0d err=%b, want 1 0", lat, er);
        end
        consume();
        xfer(32'h0001_0000, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h11AA_3344) begin
            n_bad++;
            $display("FAIL byte_merge: got %h want 11aa3344", rd);
        end
        consume();
        xfer(32'h0001_0002, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (lat !== 2 || rd !== 32'h0000_11AA) begin
            n_bad++;
            $display("FAIL byte_read_off2: lat=%0d rdata=%h, want 2 000011aa", lat, rd);
        end
        consume();
        // Half write to the upper half, then read at offset 1.
        xfer(32'h0001_0002, 1'b1, 32'h0000_5566, 4'b0011, lat, rd, er);
        consume();
        xfer(32'h0001_0001, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h0055_6633) begin
            n_bad++;
            $display("FAIL half_read_off1: got %h want 00556633", rd);
        end
        consume();
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0003, 1'b1, 32'h0000_BBCC, 4'b0011, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL misaligned_half: lat=%0d err=%b rdata=%h, want 1 1 00000000", lat, er, rd);
        end
        consume();
        xfer(32'h0001_0000, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (er !== 1'b0 || rd !== 32'h5566_3344) begin
            n_bad++;
            $display("FAIL misaligned_unchanged: err=%b rdata=%h, want 0 55663344", er, rd);
        end
        consume();
        // A byte store in the top lane is legal.
        xfer(32'h0001_0003, 1'b1, 32'h0000_0077, 4'b0001, lat, rd, er);
        n_cmp++;
        if (er !== 1'b0) begin
            n_bad++;
            $display("FAIL top_byte_write: err=%b want 0", er);
        end
        consume();
        xfer(32'h0001_0003, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h0000_0077) begin
            n_bad++;
            $display("FAIL top_byte_read: got %h want 00000077", rd);
        end
        consume();
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0FFC, 1'b1, 32'hCAFE_F00D, 4'b1111, lat, rd, er);
        consume();
        xfer(32'h0001_0FFC, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL last_word: lat=%0d err=%b rdata=%h, want 2 0 cafef00d", lat, er, rd);
        end
        consume();
        xfer(32'h0000_FFFC, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL below_base: lat=%0d err=%b rdata=%h, want 1 1 00000000", lat, er, rd);
        end
        consume();
        xfer(32'h0001_1000, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL past_end: lat=%0d err=%b rdata=%h, want 1 1 00000000", lat, er, rd);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0008, 1'b1, 32'h0BAD_C0DE, 4'b1111, lat, rd, er);
        consume();
        xfer(32'h0001_0008, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        // Offer a second request while the response is stalled.
        req_valid = 1'b1; addr = 32'h0001_000C; we = 1'b1; wdata = 32'h1234_5678; wstrb = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rdata !== 32'h0BAD_C0DE || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: valid=%b rdata=%h err=%b ready=%b, want 1 0badc0de 0 0",
                         i, rsp_valid, rdata, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL second_accept: valid=%b err=%b, want 1 0", rsp_valid, rsp_err);
        end
        consume();
        xfer(32'h0001_000C, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL second_data: got %h want 12345678", rd);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er;
        xfer(32'h0001_0010, 1'b1, 32'h0102_0304, 4'b1111, lat, rd, er);
        consume();
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h0001_0010; we = 1'b0; wstrb = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_read: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        req_valid = 1'b1; addr = 32'h0001_0010; we = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        xfer(32'h0001_0010, 1'b0, 32'h0, 4'b0000, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h0102_0304) begin
            n_bad++;
            $display("FAIL reset_write_blocked: got %h want 01020304", rd);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
